// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The master drives operands and out_ready. The slave returns the result and in_ready.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Adder/subtractor pipelined by bit slice, with a valid/ready handshake.
// Stage k adds slice k using the carry registered by stage k-1. The last stage is the output register.
module pipe_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  eb_q  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_q;

  // Lane k feeds stage k. Lane 0 comes from the ports, and lane k comes from stage k-1.
  logic [STAGES-1:0] x_v;
  logic [STAGES-1:0] x_c;
  logic [WIDTH-1:0]  x_a   [STAGES];
  logic [WIDTH-1:0]  x_eb  [STAGES];
  logic [WIDTH-1:0]  x_sum [STAGES];
  logic [STAGES-1:0] nxt_cy;
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic              nxt_ovf;

  // Stage inputs and the per-slice add.
  always_comb begin
    adv    = !vld_q[LAST] || bus.out_ready;
    x_v    = '0;
    x_c    = '0;
    nxt_cy = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      x_a[k]     = '0;
      x_eb[k]    = '0;
      x_sum[k]   = '0;
      nxt_sum[k] = '0;
    end

    // Subtraction is handled as a + ~b + !cin.
    x_v[0]   = bus.in_valid;
    x_a[0]   = bus.a;
    x_eb[0]  = bus.sub ? ~bus.b : bus.b;
    x_c[0]   = bus.sub ? ~bus.cin : bus.cin;
    x_sum[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      x_v[k]   = vld_q[k-1];
      x_a[k]   = a_q[k-1];
      x_eb[k]  = eb_q[k-1];
      x_sum[k] = sum_q[k-1];
      x_c[k]   = cy_q[k-1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      nxt_sum[k] = x_sum[k];
      {nxt_cy[k], nxt_sum[k][k*CHUNK +: CHUNK]} =
          (CHUNK+1)'(x_a[k][k*CHUNK +: CHUNK]) +
          (CHUNK+1)'(x_eb[k][k*CHUNK +: CHUNK]) +
          (CHUNK+1)'(x_c[k]);
    end

    nxt_ovf = (x_a[LAST][WIDTH-1] == x_eb[LAST][WIDTH-1]) &&
              (nxt_sum[LAST][WIDTH-1] != x_a[LAST][WIDTH-1]);
  end

  // All stages shift together on adv. The output stage loads only when a valid result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        eb_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= x_v;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (k != int'(LAST) || x_v[k]) begin
          a_q[k]   <= x_a[k];
          eb_q[k]  <= x_eb[k];
          sum_q[k] <= nxt_sum[k];
          cy_q[k]  <= nxt_cy[k];
        end
      end
      if (x_v[LAST]) ovf_q <= nxt_ovf;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.carry     = cy_q[LAST];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder (WIDTH=8, STAGES=2) using a vector table and a scoreboard.
module tb_pipe_adder;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipe_adder_if #(.WIDTH(8)) bus ();

  pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t tbl[14];

  logic [7:0] x_sum;
  logic       x_carry;
  logic       x_ovf;
  bit         chk_lat = 1'b0;
  bit         chk_b2b = 1'b0;
  int         last_pop_cyc = -1;
  bit         have_prev = 1'b0;
  logic [9:0] prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference result: a + b + cin, or a + ~b + !cin for subtraction. Returned as {ovf, carry, sum}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] eb;
    logic [8:0] r;
    logic       ov;
    eb = sub ? ~b : b;
    r  = 9'(a) + 9'(eb) + 9'(sub ? !cin : cin);
    ov = (a[7] == eb[7]) && (r[7] != a[7]);
    return {ov, r};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      have_prev = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && !bus.out_ready) begin
        if (have_prev) check("stall_stable", 32'({bus.ovf, bus.carry, bus.sum}), 32'(prev_out));
        prev_out  = {bus.ovf, bus.carry, bus.sum};
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum 0x%0h with an empty scoreboard", bus.sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 32'(bus.sum), 32'(e.sum));
          check("carry", 32'(bus.carry), 32'(e.carry));
          check("ovf", 32'(bus.ovf), 32'(e.ovf));
          if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
          if (chk_b2b && last_pop_cyc >= 0) check("gap", 32'(cyc - last_pop_cyc), 32'd1);
        end
        last_pop_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back('{sum: x_sum, carry: x_carry, ovf: x_ovf, cyc: cyc});
    end
  end

  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [9:0] e);
    bus.a    = a;
    bus.b    = b;
    bus.cin  = cin;
    bus.sub  = sub;
    x_ovf    = e[9];
    x_carry  = e[8];
    x_sum    = e[7:0];
    bus.in_valid = 1'b1;
  endtask

  // Present one operand set and hold it until the DUT accepts it.
  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input logic [9:0] e);
    bit ok;
    int n;
    set_op(a, b, cin, sub, e);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  bit done;

  initial begin
    tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[6]  = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[7]  = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[11] = '{8'h8F, 8'h0F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[12] = '{8'h40, 8'h40, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1};
    tbl[13] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    x_sum = '0; x_carry = 1'b0; x_ovf = 1'b0;

    // Outputs held at zero while in reset.
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors driven back to back: fixed latency and no gaps between results.
    chk_lat = 1'b1;
    chk_b2b = 1'b1;
    last_pop_cyc = -1;
    for (int i = 0; i < 14; i++) begin
      set_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, {tbl[i].ovf, tbl[i].carry, tbl[i].sum});
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk_b2b = 1'b0;

    // A single operation: out_valid rises exactly two cycles after the operands are presented.
    set_op(8'hFF, 8'h01, 1'b0, 1'b0, 10'b0_1_0000_0000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("lat1_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat2_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat2_sum", 32'(bus.sum), 32'h00);
    check("lat2_carry", 32'(bus.carry), 32'd1);
    @(posedge clk); #1;
    check("lat3_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: out_ready is low for 5 cycles while operands keep coming.
    chk_lat = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] a, b;
          a = 8'(8'h30 + i);
          b = 8'(8'h11 * i);
          send_op(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] a, b;
          logic cin, sub;
          a   = 8'($urandom);
          b   = 8'($urandom);
          cin = 1'($urandom);
          sub = 1'($urandom);
          send_op(a, b, cin, sub, model(a, b, cin, sub));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight: both are discarded.
    bus.out_ready = 1'b0;
    set_op(8'hFF, 8'hFF, 1'b1, 1'b0, model(8'hFF, 8'hFF, 1'b1, 1'b0));
    @(posedge clk); #1;
    set_op(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_sum", 32'(bus.sum), 32'd0);
    check("async_rst_carry", 32'(bus.carry), 32'd0);
    check("async_rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // The first edge after reset accepts operands.
    chk_lat = 1'b1;
    set_op(8'h21, 8'h43, 1'b1, 1'b0, model(8'h21, 8'h43, 1'b1, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_sum", 32'(bus.sum), 32'h65);
    drain();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale_result", 32'(bus.out_valid), 32'd0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2, number of pipeline stages; SHALL be >= 1 and divide WIDTH exactly (CHUNK = WIDTH/STAGES).
REQ-003 Ports SHALL be exactly as follows:
 - clk  in  1  single clock, all state updates on rising edge
 - rst  in  1  asynchronous, active-high reset
 - in_valid  in  1  operand set presented
 - in_ready  out  1  block accepts operands this cycle
 - a  in  WIDTH  operand A
 - b  in  WIDTH  operand B
 - cin  in  1  carry-in (add) / borrow-in (sub)
 - sub  in  1  0 = add, 1 = subtract
 - out_valid  out  1  result held on outputs
 - out_ready  in  1  downstream accepts result
 - sum  out  WIDTH  result
 - carry  out  1  carry-out (add) / not-borrow (sub)
 - ovf  out  1  two's-complement signed overflow

Function
REQ-004 Add: {carry,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-005 Subtract: {carry,sum} SHALL equal a + ~b + !cin (i.e. a - b - cin); carry=1 means no borrow.
REQ-006 ovf SHALL be 1 iff the MSBs of both effective addends (a, b or ~b) are equal and differ from sum MSB.
REQ-007 Stage k (0..STAGES-1) SHALL add bit slice [k*CHUNK +: CHUNK] using the carry registered from stage k-1 (stage 0 uses the effective carry-in); unprocessed operand slices and completed sum slices SHALL be carried forward in pipeline registers.
REQ-008 Each stage SHALL hold a valid bit; sub-mode and operands travel with their valid bit.
REQ-009 Pipeline advance signal adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-010 Operands SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-011 When adv=1 all stages SHALL shift by one, stage 0 loading in_valid (bubble if 0); when adv=0 all stage registers SHALL hold.
REQ-012 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 with no backpressure.
REQ-013 Throughput SHALL be one result per cycle while out_ready=1; no bubbles inserted by the block.
REQ-014 sum, carry, ovf SHALL be registered outputs and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 A result SHALL be consumed on a rising edge where out_valid && out_ready; if no new result arrives, out_valid SHALL drop to 0 the following cycle.
REQ-016 Simultaneous consume and accept SHALL be lossless: both handshakes complete in the same cycle.
REQ-017 Data bits of invalid stages are don't-care internally but sum/carry/ovf SHALL update only when a valid result enters the output stage.
REQ-018 STAGES=1 SHALL degenerate to a single registered full adder with handshake, latency 1.

Reset
REQ-019 rst=1 SHALL immediately clear all stage valid bits, out_valid, sum, carry, ovf to 0, independent of clk.
REQ-020 Reset mid-operation SHALL discard all in-flight operands; no result SHALL appear after rst deasserts.
REQ-021 First rising edge after rst deasserts SHALL accept operands (in_ready=1 out of reset).

Verification (WIDTH=8, STAGES=2)
REQ-022 a=0xFF, b=0x01, cin=0, sub=0, out_ready=1 -> two cycles later out_valid=1, sum=0x00, carry=1, ovf=0.
REQ-023 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, carry=0, ovf=1; a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, carry=0, ovf=0.
REQ-024 Four back-to-back operand sets (0+0, 0+1, 1+0, 1+1, cin=0) with out_ready=1 -> sums 0x00,0x01,0x01,0x02 on four consecutive cycles starting cycle 2.
REQ-025 out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 once output holds a result, output stable, no operand lost or duplicated after out_ready returns to 1.
REQ-026 rst pulsed while two operand sets in flight -> out_valid=0 and sum/carry/ovf=0 immediately; neither result ever emitted.
